instruction_mem_pipe: RTL

INSTRUCTION_MEM_PIPE -- requirements
Module: instruction_mem_pipe

---
 rtl/instruction_mem_pipe_pkg.sv | 22 ++
 rtl/instruction_mem_pipe_ram.sv | 42 ++++
 rtl/instruction_mem_pipe.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/instruction_mem_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_mem_pipe_pkg
// Description : Shared types and constants for the instruction memory
//               pipeline stage: controller state encoding and the default
//               no-operation word.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_mem_pipe_pkg;

    // Controller states: INIT clears memory, RUN fetches, LOAD accepts writes
    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // Default instruction word presented whenever no real fetch is available
    localparam logic [31:0] c_NOP_WORD = 32'h0000_0000;

endpackage : instruction_mem_pipe_pkg
`default_nettype wire

// File: rtl/instruction_mem_pipe_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : Single-port synchronous RAM, DEPTH x DATA_W. One shared
//               address; a write takes priority over a read in the same
//               cycle. The read data register only updates when a read is
//               enabled, so holding i_re low freezes the last read word.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram
    import instruction_mem_pipe_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];
    logic [DATA_W-1:0] r_rdata;

    // Storage array and registered read port; no reset on the array so it
    // maps onto block RAM, the controller masks the read register instead
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : imem_ram
`default_nettype wire

// File: rtl/instruction_mem_pipe.sv
`default_nettype none
// ============================================================================
// Module      : instruction_mem_pipe
// Description : Instruction fetch memory stage. After reset the memory is
//               cleared to NOP_WORD one word per cycle (INIT), then serves
//               1-cycle-latency fetches (RUN) with stall/flush control. A
//               LOAD mode streams new program words in from word 0 upward,
//               saturating at the last word.
//               Optional build macro: IMEM_RANGE_CHECK_EN - when defined,
//               out-of-range or misaligned fetch addresses return NOP_WORD
//               with Addr_err raised; when undefined the index simply wraps
//               and Addr_err stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_mem_pipe
    import instruction_mem_pipe_pkg::*;
#(
    parameter int                 ADDR_W   = 8,
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  NOP_WORD = DATA_W'(c_NOP_WORD)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Address,
    input  logic              Stall,
    input  logic              Flush,
    output logic [DATA_W-1:0] Instruction,
    output logic              Instr_valid,
    output logic              Busy,
    input  logic              Load_start,
    input  logic              Load_valid,
    input  logic [DATA_W-1:0] Load_data,
    input  logic              Load_done,
    output logic              Load_full,
    output logic              Addr_err
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = {ADDR_W{1'b1}};

`ifdef IMEM_RANGE_CHECK_EN
    localparam bit c_RANGE_CHECK = 1'b1;
`else
    localparam bit c_RANGE_CHECK = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_init_cnt;   // INIT clear address
    logic [ADDR_W-1:0] r_wptr;       // LOAD write pointer
    logic              r_full;       // write pointer saturated at last word
    logic              r_show;       // RAM read register holds a real fetch
    logic              r_err;        // current output cycle is an address error

    logic [ADDR_W-1:0] w_index;
    logic              w_addr_bad;
    logic              w_load_wr;
    logic              w_fetch;

    logic              w_ram_we;
    logic              w_ram_re;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    assign w_index = Address[ADDR_W+1:2];

    // Anything above the word-index field, or a non-word-aligned byte
    // address, is illegal; the check collapses to 0 when disabled.
    assign w_addr_bad = c_RANGE_CHECK &&
                        ((Address[31:ADDR_W+2] != '0) || (Address[1:0] != 2'b00));

    // A LOAD write is accepted only until the pointer saturates
    assign w_load_wr = (r_state == ST_LOAD) && Load_valid && !r_full;

    // A new fetch is launched in RUN unless the pipe is held or squashed
    assign w_fetch = (r_state == ST_RUN) && !Stall && !Flush;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; Load_start outranks a simultaneous Load_done in RUN
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_init_cnt == c_LAST_IDX) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (Load_start) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (Load_done) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // RAM port steering: INIT and LOAD own the port for writes, RUN reads
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = w_index;
        w_ram_wdata = NOP_WORD;
        case (r_state)
            ST_INIT: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = r_init_cnt;
                w_ram_wdata = NOP_WORD;
            end
            ST_LOAD: begin
                w_ram_we    = w_load_wr;
                w_ram_addr  = r_wptr;
                w_ram_wdata = Load_data;
            end
            ST_RUN: begin
                w_ram_re    = w_fetch;
            end
            default: begin
                w_ram_we    = 1'b0;
            end
        endcase
    end

    // Init counter, load pointer and saturation flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_init_cnt <= '0;
            r_wptr     <= '0;
            r_full     <= 1'b0;
        end else begin
            if (r_state == ST_INIT) begin
                r_init_cnt <= r_init_cnt + 1'b1;
            end
            if ((r_state == ST_RUN) && Load_start) begin
                r_wptr <= '0;
                r_full <= 1'b0;
            end else if (w_load_wr) begin
                // Saturate on the last word rather than wrapping to word 0
                if (r_wptr == c_LAST_IDX) begin
                    r_full <= 1'b1;
                end else begin
                    r_wptr <= r_wptr + 1'b1;
                end
            end
        end
    end

    // Output qualifiers tracking what the RAM read register currently holds
    always_ff @(posedge clk) begin
        if (reset) begin
            r_show <= 1'b0;
            r_err  <= 1'b0;
        end else if (r_state == ST_RUN) begin
            if (Flush || Load_start) begin
                // Squash, or leaving for LOAD where outputs must read as NOP
                r_show <= 1'b0;
                r_err  <= 1'b0;
            end else if (!Stall) begin
                r_show <= !w_addr_bad;
                r_err  <= w_addr_bad;
            end
        end else begin
            r_show <= 1'b0;
            r_err  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    imem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs: all derived directly from registers
    // ------------------------------------------------------------------
    assign Instruction = r_show ? w_ram_rdata : NOP_WORD;
    assign Instr_valid = r_show;
    assign Busy        = (r_state != ST_RUN);
    assign Load_full   = r_full;
    assign Addr_err    = r_err;

endmodule : instruction_mem_pipe
`default_nettype wire
